gauss_array_feeder: RTL and testbench

//  Transmit side of the processor-array stream protocol. Fetches a row-major GF matrix from local RAM
//  and drives the head processor of the linear systolic array one element per cycle, framed by

---
 rtl/gauss_array_feeder_pkg.sv | 37 +++
 rtl/gauss_array_feeder_if.sv | 32 +++
 rtl/gauss_feed_counter.sv | 57 +++++
 rtl/gauss_array_feeder.sv | 164 ++++++++++++++++
 tb/tb_gauss_array_feeder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/gauss_array_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gauss_array_feeder_pkg
// Brief    : Op codes, gauss_op encodings and FSM state type shared by the
//            array feeder and the processor array.
// Revision : 1.0 - initial release
// ============================================================================
package gauss_array_feeder_pkg;

    localparam int unsigned OP_GAUSS        = 1;
    localparam int unsigned OP_LOAD_KEY     = 3;
    localparam int unsigned OP_EVAL         = 4;
    localparam int unsigned OP_LOAD_B       = 5;
    localparam int unsigned OP_MUL_RAND_SIG = 6;
    localparam int unsigned OP_LOAD_R       = 8;
    localparam int unsigned OP_ACC          = 9;

    localparam logic [1:0] GOP_PASS  = 2'b00;
    localparam logic [1:0] GOP_ELIM  = 2'b01;
    localparam logic [1:0] GOP_ADD   = 2'b10;
    localparam logic [1:0] GOP_START = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } feed_state_t;

    // Only GAUSS commands run the array in elimination mode; everything else passes through.
    function automatic logic [1:0] gauss_op_for(input int unsigned op);
        return (op == OP_GAUSS) ? GOP_START : GOP_PASS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gauss_array_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : gauss_array_feeder_if
// Brief    : Command handshake and status between the sequencer (master) and
//            the array feeder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface gauss_array_feeder_if #(
    parameter int OP_CODE_LEN = 4,
    parameter int ADDR_W      = 10,
    parameter int DIM_W       = 7
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [OP_CODE_LEN-1:0] cmd_op;
    logic [ADDR_W-1:0]      cmd_base;
    logic [DIM_W-1:0]       cmd_rows;
    logic [DIM_W-1:0]       cmd_cols;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_rows, cmd_cols,
        input  cmd_ready, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_rows, cmd_cols,
        output cmd_ready, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/gauss_feed_counter.sv
`default_nettype none
// ============================================================================
// Module   : gauss_feed_counter
// Brief    : Row/column walker and RAM read-address generator for the feeder.
// Revision : 1.0 - initial release
// ============================================================================
module gauss_feed_counter #(
    parameter int ADDR_W = 10,
    parameter int DIM_W  = 7
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic              advance,
    input  wire logic [ADDR_W-1:0] base,
    input  wire logic [DIM_W-1:0]  rows,
    input  wire logic [DIM_W-1:0]  cols,
    output logic      [ADDR_W-1:0] addr,
    output logic                   last
);
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_rows_m1;
    logic [DIM_W-1:0]  r_cols_m1;
    logic [ADDR_W-1:0] r_addr;

    // Dimensions are stored minus one so the last-element test is a plain compare;
    // load is never issued for an empty matrix.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_rows_m1 <= '0;
            r_cols_m1 <= '0;
            r_addr    <= '0;
        end else if (load) begin
            r_row     <= '0;
            r_col     <= '0;
            r_rows_m1 <= rows - DIM_W'(1);
            r_cols_m1 <= cols - DIM_W'(1);
            r_addr    <= base;
        end else if (advance) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_col == r_cols_m1) begin
                r_col <= '0;
                r_row <= r_row + DIM_W'(1);
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

    assign addr = r_addr;
    assign last = (r_row == r_rows_m1) && (r_col == r_cols_m1);

endmodule
`default_nettype wire

// File: rtl/gauss_array_feeder.sv
`default_nettype none
// ============================================================================
// Module   : gauss_array_feeder
// Brief    : Streams a row-major GF matrix from local RAM into PE0 of the
//            systolic array, framed by start/finish with op sideband.
// Revision : 1.0 - initial release
// ============================================================================
module gauss_array_feeder
    import gauss_array_feeder_pkg::*;
#(
    parameter int GF_BIT      = 4,
    parameter int OP_CODE_LEN = 4,
    parameter int ADDR_W      = 10,
    parameter int DIM_W       = 7,
    parameter int N_PE        = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    gauss_array_feeder_if.slave         cmd,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_rd_addr,
    input  wire logic [GF_BIT-1:0]      mem_rd_data,
    output logic                        start_out,
    output logic                        finish_out,
    output logic [OP_CODE_LEN-1:0]      op_out,
    output logic [1:0]                  gauss_op_out,
    output logic [GF_BIT-1:0]           data_out,
    output logic [GF_BIT-1:0]           dataA_out,
    output logic [GF_BIT-1:0]           dataB_out
);
    localparam int DRAIN_W = $clog2(N_PE + 1);

    feed_state_t            r_state;
    logic                   r_cmd_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_rd_en;
    logic                   r_start;
    logic                   r_stream;
    logic                   r_finish;
    logic [OP_CODE_LEN-1:0] r_op;
    logic [OP_CODE_LEN-1:0] r_op_out;
    logic [1:0]             r_gop;
    logic [DRAIN_W-1:0]     r_drain_cnt;

    logic                   w_accept;
    logic                   w_empty;
    logic                   w_load;
    logic                   w_advance;
    logic                   w_last;
    logic [ADDR_W-1:0]      w_addr;

    assign w_accept  = cmd.cmd_valid && r_cmd_ready;
    assign w_empty   = (cmd.cmd_rows == '0) || (cmd.cmd_cols == '0);
    assign w_load    = w_accept && !w_empty;
    // The address counter is one element ahead of data_out and parks on the last address.
    assign w_advance = r_rd_en && !w_last && ((r_state == ST_FETCH) || (r_state == ST_STREAM));

    gauss_feed_counter #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .advance (w_advance),
        .base    (cmd.cmd_base),
        .rows    (cmd.cmd_rows),
        .cols    (cmd.cmd_cols),
        .addr    (w_addr),
        .last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_start     <= 1'b0;
            r_stream    <= 1'b0;
            r_finish    <= 1'b0;
            r_op        <= '0;
            r_op_out    <= '0;
            r_gop       <= GOP_PASS;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= cmd.cmd_op;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_empty) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state  <= ST_STREAM;
                    r_start  <= 1'b1;
                    r_stream <= 1'b1;
                    r_op_out <= r_op;
                    r_gop    <= gauss_op_for(32'(r_op));
                    if (w_last) r_rd_en <= 1'b0;
                end
                ST_STREAM: begin
                    r_start <= 1'b0;
                    // Read strobe already low means this cycle carries the final element.
                    if (!r_rd_en) begin
                        r_state     <= ST_DRAIN;
                        r_stream    <= 1'b0;
                        r_finish    <= 1'b1;
                        r_drain_cnt <= DRAIN_W'(N_PE - 1);
                    end else if (w_last) begin
                        r_rd_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state  <= ST_DONE;
                        r_finish <= 1'b0;
                        r_op_out <= '0;
                        r_gop    <= GOP_PASS;
                        r_done   <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = r_cmd_ready;
    assign cmd.busy      = r_busy;
    assign cmd.done      = r_done;
    assign mem_rd_en     = r_rd_en;
    assign mem_rd_addr   = w_addr;
    assign start_out     = r_start;
    assign finish_out    = r_finish;
    assign op_out        = r_op_out;
    assign gauss_op_out  = r_gop;
    // RAM output is already registered; the stream flag gates it so idle/drain cycles carry zero.
    assign data_out      = r_stream ? mem_rd_data : '0;
    assign dataA_out     = '0;
    assign dataB_out     = '0;

endmodule
`default_nettype wire

// File: tb/tb_gauss_array_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gauss_array_feeder
// Brief    : Directed and randomized commands checked cycle by cycle against
//            a timeline model of the feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gauss_array_feeder;
    import gauss_array_feeder_pkg::*;

    localparam int GF_BIT      = 4;
    localparam int OP_CODE_LEN = 4;
    localparam int ADDR_W      = 10;
    localparam int DIM_W       = 7;
    localparam int N_PE        = 64;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam logic [23:0] IDLE_VEC = 24'h800000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gauss_array_feeder_if #(.OP_CODE_LEN(OP_CODE_LEN), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) cmd_if ();

    logic                   mem_rd_en;
    logic [ADDR_W-1:0]      mem_rd_addr;
    logic [GF_BIT-1:0]      mem_rd_data = '0;
    logic                   start_out, finish_out;
    logic [OP_CODE_LEN-1:0] op_out;
    logic [1:0]             gauss_op_out;
    logic [GF_BIT-1:0]      data_out, dataA_out, dataB_out;

    gauss_array_feeder #(
        .GF_BIT(GF_BIT), .OP_CODE_LEN(OP_CODE_LEN), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .N_PE(N_PE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .start_out    (start_out),
        .finish_out   (finish_out),
        .op_out       (op_out),
        .gauss_op_out (gauss_op_out),
        .data_out     (data_out),
        .dataA_out    (dataA_out),
        .dataB_out    (dataB_out)
    );

    logic [GF_BIT-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] obs_vec();
        return {cmd_if.cmd_ready, cmd_if.busy, cmd_if.done, mem_rd_en, start_out, finish_out,
                op_out, gauss_op_out, data_out, dataA_out, dataB_out};
    endfunction

    // Expected outputs k cycles after the accepting edge, straight from the protocol timeline.
    function automatic logic [23:0] model(input int k, input int op, input int base, input int rows,
                                          input int cols, output bit addr_chk, output int addr);
        int n = rows * cols;
        bit ready = 1'b0, busy = 1'b1, done = 1'b0, rd = 1'b0, st = 1'b0, fin = 1'b0;
        int opo = 0, gop = 0, data = 0;
        addr_chk = 1'b0;
        addr     = 0;
        if (n == 0) begin
            if (k == 1) done = 1'b1;
            else begin ready = 1'b1; busy = 1'b0; end
        end else begin
            if (k <= n) begin rd = 1'b1; addr_chk = 1'b1; addr = (base + k - 1) % DEPTH; end
            if (k >= 2 && k <= n + 1) begin data = int'(ram[(base + k - 2) % DEPTH]); st = (k == 2); end
            if (k >= n + 2 && k <= n + 1 + N_PE) fin = 1'b1;
            if (k >= 2 && k <= n + 1 + N_PE) begin opo = op; gop = (op == 1) ? 3 : 0; end
            if (k == n + 2 + N_PE) done = 1'b1;
            if (k >= n + 3 + N_PE) begin ready = 1'b1; busy = 1'b0; end
        end
        return {ready, busy, done, rd, st, fin, 4'(opo), 2'(gop), 4'(data), 8'h00};
    endfunction

    task automatic run_cmd(input int op, input int base, input int rows, input int cols,
                           input bit hold, input int abort_at);
        int total;
        bit achk;
        int aexp;
        logic [23:0] exp;
        check("ready_before_accept", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_CODE_LEN'(op);
        cmd_if.cmd_base  = ADDR_W'(base);
        cmd_if.cmd_rows  = DIM_W'(rows);
        cmd_if.cmd_cols  = DIM_W'(cols);
        @(posedge clk); #1;
        if (!hold) cmd_if.cmd_valid = 1'b0;
        total = (rows * cols == 0) ? 2 : rows * cols + 3 + N_PE;
        for (int k = 1; k <= total; k++) begin
            exp = model(k, op, base, rows, cols, achk, aexp);
            check($sformatf("op%0d_%0dx%0d_cyc%0d_outputs", op, rows, cols, k), 32'(obs_vec()), 32'(exp));
            if (achk) check($sformatf("op%0d_cyc%0d_rd_addr", op, k), 32'(mem_rd_addr), 32'(aexp));
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("abort_outputs", 32'(obs_vec()), 32'(IDLE_VEC));
                check("abort_rd_addr", 32'(mem_rd_addr), 32'd0);
                repeat (3) begin
                    @(posedge clk); #1;
                    check("abort_no_done", 32'(obs_vec()), 32'(IDLE_VEC));
                end
                return;
            end
            if (k < total) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int ops [7] = '{1, 3, 4, 5, 6, 8, 9};
        for (int i = 0; i < DEPTH; i++) ram[i] = GF_BIT'($urandom_range(0, 15));
        for (int i = 0; i < 6; i++) ram[16 + i] = GF_BIT'(i + 1);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_base  = '0;
        cmd_if.cmd_rows  = '0;
        cmd_if.cmd_cols  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs_vec()), 32'(IDLE_VEC));
        check("reset_rd_addr", 32'(mem_rd_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(1, 'h010, 2, 3, 1'b0, 0);               // data 1..6, gauss framing
        run_cmd(4, 'h123, 0, 5, 1'b0, 0);               // empty: rows = 0
        run_cmd(6, 'h040, 3, 0, 1'b0, 0);               // empty: cols = 0
        run_cmd(6, DEPTH - 2, 1, 4, 1'b0, 0);           // address wrap
        run_cmd(4, int'($urandom_range(0, DEPTH - 1)), 1, 1, 1'b0, 0);
        run_cmd(1, int'($urandom_range(0, DEPTH - 1)), 2, 4, 1'b0, 4);   // reset on 3rd stream cycle
        run_cmd(1, int'($urandom_range(0, DEPTH - 1)), 2, 2, 1'b0, 0);
        run_cmd(1, int'($urandom_range(0, DEPTH - 1)), 1, 2, 1'b1, 0);   // back-to-back, valid held
        run_cmd(9, int'($urandom_range(0, DEPTH - 1)), 2, 2, 1'b0, 0);
        run_cmd(3, int'($urandom_range(0, DEPTH - 1)), 2, 127, 1'b0, 0); // column counter at full width

        repeat (6) begin
            run_cmd(ops[$urandom_range(0, 6)], int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 5)), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
